// File: rtl/lsu_mem_if_if.sv
// lsu_mem_if_if: CPU data-port and data-RAM signals of the load/store unit.
interface lsu_mem_if_if #(parameter int ADDR_WIDTH = 32);
  logic                  cpu_valid;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [2:0]            cpu_funct3;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_read;
  logic                  ram_write;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  modport master (
    output cpu_valid, cpu_write, cpu_addr, cpu_funct3, cpu_wdata, ram_rdata,
    input  cpu_rdata, cpu_ready, cpu_err, ram_addr, ram_read, ram_write, ram_wdata
  );
  modport slave (
    input  cpu_valid, cpu_write, cpu_addr, cpu_funct3, cpu_wdata, ram_rdata,
    output cpu_rdata, cpu_ready, cpu_err, ram_addr, ram_read, ram_write, ram_wdata
  );
endinterface

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store to word RAM with sub-word RMW; LSU_MISALIGN_TRAP_EN enables misalign/illegal traps.
module lsu_mem_if #(
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  lsu_mem_if_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_DATA, ST_REQ, RMW_REQ, RMW_DATA, RMW_WR, DONE} state_t;
  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  sz_q;
  logic        sgn_q;
  logic [15:0] wd_q;
  logic        illegal;
  logic        err_in;
  logic [1:0]  sz_in;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] ld_val;
  logic [31:0] merged;
  // size code: 0 byte, 1 half, 2 word; anything illegal collapses to word
  always_comb begin
    illegal = bus.cpu_funct3 == 3'b011 || bus.cpu_funct3[2:1] == 2'b11 || (bus.cpu_write && bus.cpu_funct3[2]);
    sz_in = illegal ? 2'd2 : bus.cpu_funct3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    err_in = illegal || (sz_in == 2'd1 && bus.cpu_addr[0]) || (sz_in == 2'd2 && bus.cpu_addr[1:0] != 2'b00);
`else
    err_in = 1'b0;
`endif
  end
  always_comb begin
    b_sel = bus.ram_rdata[{off_q, 3'b000} +: 8];
    h_sel = off_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    ld_val = sz_q == 2'd0 ? {{24{sgn_q & b_sel[7]}}, b_sel} :
             sz_q == 2'd1 ? {{16{sgn_q & h_sel[15]}}, h_sel} : bus.ram_rdata;
    merged = bus.ram_rdata;
    if (sz_q == 2'd0) merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
    else if (sz_q == 2'd1) merged[{off_q[1], 4'b0000} +: 16] = wd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      off_q         <= '0;
      sz_q          <= '0;
      sgn_q         <= 1'b0;
      wd_q          <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      bus.ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cpu_valid) begin
          bus.ram_addr <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          off_q        <= bus.cpu_addr[1:0];
          sz_q         <= sz_in;
          sgn_q        <= ~bus.cpu_funct3[2];
          wd_q         <= bus.cpu_wdata[15:0];
          if (err_in) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= '0;
            state         <= DONE;
          end else if (!bus.cpu_write) begin
            bus.ram_read <= 1'b1;
            state        <= LD_REQ;
          end else if (sz_in == 2'd2) begin
            bus.ram_write <= 1'b1;
            bus.ram_wdata <= bus.cpu_wdata;
            state         <= ST_REQ;
          end else begin
            bus.ram_read <= 1'b1;
            state        <= RMW_REQ;
          end
        end
        LD_REQ: begin
          bus.ram_read <= 1'b0;
          state        <= LD_DATA;
        end
        LD_DATA: begin
          bus.cpu_rdata <= ld_val;
          bus.cpu_ready <= 1'b1;
          state         <= DONE;
        end
        ST_REQ, RMW_WR: begin
          bus.ram_write <= 1'b0;
          bus.cpu_rdata <= '0;
          bus.cpu_ready <= 1'b1;
          state         <= DONE;
        end
        RMW_REQ: begin
          bus.ram_read <= 1'b0;
          state        <= RMW_DATA;
        end
        RMW_DATA: begin
          bus.ram_wdata <= merged;
          bus.ram_write <= 1'b1;
          state         <= RMW_WR;
        end
        DONE: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed and randomized checks of lsu_mem_if against a word-array reference model.
module tb_lsu_mem_if;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  lsu_mem_if_if #(.ADDR_WIDTH(32)) bus ();
  lsu_mem_if #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // data RAM: registered read, 0 when not reading
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr[12:2]] <= bus.ram_wdata;
    bus.ram_rdata <= bus.ram_read ? mem[bus.ram_addr[12:2]] : 32'h0;
  end

  function automatic bit m_err(bit wr, logic [31:0] a, logic [2:0] f3);
    if (!TRAP) return 1'b0;
    if (f3 == 3 || f3 >= 6 || (wr && f3 >= 4)) return 1'b1;
    if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
    if (f3 == 2 && a[1:0] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_kind(bit wr, logic [2:0] f3);
    if (f3 == 0 || (f3 == 4 && !wr)) return 0;
    if (f3 == 1 || (f3 == 5 && !wr)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] w, v;
    w = ref_mem[a[12:2]];
    case (m_kind(1'b0, f3))
      0: begin
        v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v - 32'd256;
      end
      1: begin
        v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int sh;
    logic [31:0] msk;
    case (m_kind(1'b1, f3))
      0: begin sh = 8 * int'(a[1:0]);  msk = 32'hFF << sh; end
      1: begin sh = 16 * int'(a[1]);   msk = 32'hFFFF << sh; end
      default: begin sh = 0; msk = 32'hFFFFFFFF; end
    endcase
    ref_mem[a[12:2]] = (ref_mem[a[12:2]] & ~msk) | ((wd << sh) & msk);
  endtask

  // starts in an IDLE cycle (just after a negedge), ends in the next IDLE cycle
  task automatic access(input logic wr, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr, output int bad_bus);
    bus.cpu_valid = 1'b1; bus.cpu_write = wr; bus.cpu_addr = a; bus.cpu_funct3 = f3; bus.cpu_wdata = wd;
    lat = 99; rd = 'x; er = 'x; nrd = 0; nwr = 0; bad_bus = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.cpu_valid = 1'b0; bus.cpu_write = 1'($urandom); bus.cpu_addr = $urandom;
        bus.cpu_funct3 = 3'($urandom); bus.cpu_wdata = $urandom;
      end
      nrd += int'(bus.ram_read);
      nwr += int'(bus.ram_write);
      if (bus.ram_read && bus.ram_write) bad_bus++;
      if ((bus.ram_read || bus.ram_write) && bus.ram_addr !== (a & ~32'h3)) bad_bus++;
      if (bus.cpu_ready) begin
        lat = i; rd = bus.cpu_rdata; er = bus.cpu_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cpu_valid = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_funct3 = '0; bus.cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.cpu_ready, bus.cpu_err, bus.ram_read, bus.ram_write} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {bus.cpu_ready, bus.cpu_err, bus.ram_read, bus.ram_write}); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
    n_cmp++; if ({bus.ram_addr, bus.ram_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_ram: got %h/%h want 0/0", bus.ram_addr, bus.ram_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    int lat, nrd, nwr, bb; logic [31:0] rd; logic er;
    access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, lat, rd, er, nrd, nwr, bb);
    m_store(32'h10, 3'b010, 32'hDEADBEEF);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if (nwr !== 1 || nrd !== 0 || bb !== 0) begin n_bad++; $display("FAIL sw_strobes: got wr=%0d rd=%0d bus=%0d want 1 0 0", nwr, nrd, bb); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_ram: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_loads();
    logic [31:0] a_t [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  f_t [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] e_t [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    int lat, nrd, nwr, bb; logic [31:0] rd; logic er;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, a_t[i], f_t[i], $urandom, lat, rd, er, nrd, nwr, bb);
      n_cmp++; if (rd !== e_t[i]) begin n_bad++; $display("FAIL load_%0d_rdata: got %h want %h", i, rd, e_t[i]); end
      n_cmp++; if (lat !== 3 || er !== 1'b0) begin n_bad++; $display("FAIL load_%0d_lat_err: got %0d/%b want 3/0", i, lat, er); end
      n_cmp++; if (nrd !== 1 || nwr !== 0 || bb !== 0) begin n_bad++; $display("FAIL load_%0d_strobes: got rd=%0d wr=%0d bus=%0d want 1 0 0", i, nrd, nwr, bb); end
    end
  endtask

  task automatic test_subword_store();
    int lat, nrd, nwr, bb; logic [31:0] rd; logic er;
    access(1'b1, 32'h11, 3'b000, 32'h12345677, lat, rd, er, nrd, nwr, bb);
    m_store(32'h11, 3'b000, 32'h12345677);
    n_cmp++; if (mem[4] !== 32'hDEAD77EF) begin n_bad++; $display("FAIL sb_ram: got %h want dead77ef", mem[4]); end
    n_cmp++; if (lat !== 4 || nrd !== 1 || nwr !== 1 || bb !== 0) begin n_bad++; $display("FAIL sb_timing: got lat=%0d rd=%0d wr=%0d bus=%0d want 4 1 1 0", lat, nrd, nwr, bb); end
    access(1'b1, 32'h12, 3'b001, 32'hAAAA5555, lat, rd, er, nrd, nwr, bb);
    m_store(32'h12, 3'b001, 32'hAAAA5555);
    n_cmp++; if (mem[4] !== 32'h555577EF) begin n_bad++; $display("FAIL sh_ram: got %h want 555577ef", mem[4]); end
    n_cmp++; if (lat !== 4 || nrd !== 1 || nwr !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL sh_timing: got lat=%0d rd=%0d wr=%0d rdata=%h want 4 1 1 0", lat, nrd, nwr, rd); end
  endtask

  task automatic test_reset_abort();
    int saw_wr = 0, saw_rdy = 0;
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_funct3 = 3'b000; bus.cpu_wdata = 32'h0;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    saw_wr += int'(bus.ram_write); saw_rdy += int'(bus.cpu_ready);
    @(negedge clk);
    saw_wr += int'(bus.ram_write); saw_rdy += int'(bus.cpu_ready);
    rst = 1'b1;
    @(negedge clk);
    saw_wr += int'(bus.ram_write); saw_rdy += int'(bus.cpu_ready);
    n_cmp++; if ({bus.cpu_rdata, bus.cpu_err, bus.ram_addr, bus.ram_read, bus.ram_wdata} !== 98'h0) begin n_bad++; $display("FAIL abort_outputs: got rdata=%h addr=%h wdata=%h rd=%b err=%b want all 0", bus.cpu_rdata, bus.ram_addr, bus.ram_wdata, bus.ram_read, bus.cpu_err); end
    rst = 1'b0;
    @(negedge clk);
    saw_wr += int'(bus.ram_write); saw_rdy += int'(bus.cpu_ready);
    n_cmp++; if (saw_wr !== 0 || saw_rdy !== 0) begin n_bad++; $display("FAIL abort_strobes: got wr=%0d ready=%0d want 0 0", saw_wr, saw_rdy); end
    n_cmp++; if (mem[4] !== ref_mem[4]) begin n_bad++; $display("FAIL abort_ram: got %h want %h", mem[4], ref_mem[4]); end
  endtask

  task automatic test_misalign();
    int lat, nrd, nwr, bb; logic [31:0] rd; logic er;
    access(1'b0, 32'h11, 3'b010, 32'h0, lat, rd, er, nrd, nwr, bb);
    n_cmp++; if (lat !== (TRAP ? 1 : 3)) begin n_bad++; $display("FAIL misalign_latency: got %0d want %0d", lat, TRAP ? 1 : 3); end
    n_cmp++; if (er !== TRAP) begin n_bad++; $display("FAIL misalign_err: got %b want %b", er, TRAP); end
    n_cmp++; if (rd !== (TRAP ? 32'h0 : ref_mem[4])) begin n_bad++; $display("FAIL misalign_rdata: got %h want %h", rd, TRAP ? 32'h0 : ref_mem[4]); end
    n_cmp++; if (nrd !== (TRAP ? 0 : 1) || nwr !== 0) begin n_bad++; $display("FAIL misalign_strobes: got rd=%0d wr=%0d", nrd, nwr); end
  endtask

  task automatic test_back_to_back();
    int c1 = -1, c2 = -1, both = 0, pulses = 0;
    logic [31:0] rd1 = 'x, rd2 = 'x;
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_funct3 = 3'b010;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ram_read && bus.ram_write) both++;
      if (bus.cpu_ready) begin
        pulses++;
        if (c1 < 0) begin c1 = i; rd1 = bus.cpu_rdata; bus.cpu_addr = 32'h14; end
        else begin c2 = i; rd2 = bus.cpu_rdata; break; end
      end
    end
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (c2 - c1 !== 4 || pulses !== 2) begin n_bad++; $display("FAIL b2b_spacing: got gap=%0d pulses=%0d want 4 2", c2 - c1, pulses); end
    n_cmp++; if (rd1 !== ref_mem[4] || rd2 !== ref_mem[5]) begin n_bad++; $display("FAIL b2b_rdata: got %h %h want %h %h", rd1, rd2, ref_mem[4], ref_mem[5]); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL b2b_both_strobes: got %0d want 0", both); end
  endtask

  task automatic test_random();
    int lat, nrd, nwr, bb, k, e_lat, e_nrd, e_nwr;
    logic [31:0] a, wd, rd, e_rd; logic [2:0] f3; logic wr, er, e_er;
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (wr && !TRAP && f3[2:1] == 2'b10) f3[2] = 1'b0;
      a  = $urandom & 32'hFFFFE03F;
      wd = $urandom;
      k = m_kind(wr, f3);
      e_er  = m_err(wr, a, f3);
      e_lat = e_er ? 1 : !wr ? 3 : k == 2 ? 2 : 4;
      e_nrd = e_er ? 0 : (!wr || k != 2) ? 1 : 0;
      e_nwr = (e_er || !wr) ? 0 : 1;
      e_rd  = (e_er || wr) ? 32'h0 : m_load(a, f3);
      if (wr && !e_er) m_store(a, f3, wd);
      access(wr, a, f3, wd, lat, rd, er, nrd, nwr, bb);
      n_cmp++; if (lat !== e_lat || er !== e_er) begin n_bad++; $display("FAIL rnd%0d_lat_err wr=%b f3=%0d a=%h: got %0d/%b want %0d/%b", n, wr, f3, a, lat, er, e_lat, e_er); end
      n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL rnd%0d_rdata wr=%b f3=%0d a=%h: got %h want %h", n, wr, f3, a, rd, e_rd); end
      n_cmp++; if (nrd !== e_nrd || nwr !== e_nwr || bb !== 0) begin n_bad++; $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d bus=%0d want %0d %0d 0", n, nrd, nwr, bb, e_nrd, e_nwr); end
      n_cmp++; if (mem[a[12:2]] !== ref_mem[a[12:2]]) begin n_bad++; $display("FAIL rnd%0d_ram a=%h: got %h want %h", n, a, mem[a[12:2]], ref_mem[a[12:2]]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_store_word();
    test_loads();
    test_subword_store();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store interface between the CPU data port and the word-only, 1-cycle-read-latency data RAM (8 KB, 32-bit words, word address = byte address bits [12:2]).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word reads and writes.
- Sub-word stores use read-modify-write. Loads are byte-selected and sign- or zero-extended.
- Holds the CPU with a valid/ready handshake until each access completes.

Parameters:
- ADDR_WIDTH, 32, width of the CPU and RAM byte address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_valid  in  1  request present; held stable by the CPU until cpu_ready.
- cpu_write  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_funct3  in  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- cpu_rdata  out  32  load result, extended; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  misaligned or illegal access; valid while cpu_ready=1.
- ram_addr  out  ADDR_WIDTH  byte address to RAM; low two bits always 00.
- ram_read  out  1  RAM read enable.
- ram_write  out  1  RAM write enable, full word.
- ram_wdata  out  32  word to RAM.
- ram_rdata  in  32  RAM registered read data; valid in the cycle after ram_read=1, 0 otherwise.

Behaviour:
- All outputs are registered or decoded from registered state. Reset values: cpu_rdata=0, cpu_ready=0, cpu_err=0, ram_addr=0, ram_read=0, ram_write=0, ram_wdata=0, state=IDLE.
- The request (addr, funct3, wdata, write) is latched on the accepting edge: the edge where state=IDLE and cpu_valid=1.
- ram_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00} in every non-IDLE state.
- States and transitions:
  - IDLE: no RAM strobes. On accept:
    - error → DONE;
    - load → LD_REQ;
    - store with funct3=010 → ST_REQ;
    - store with funct3 000/001 → RMW_REQ.
  - LD_REQ: ram_read=1 → LD_DATA.
  - LD_DATA: ram_read=0. On the exit edge, cpu_rdata ← extract(ram_rdata) → DONE.
    - B/BU select byte addr[1:0]; H/HU select half addr[1].
    - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - ST_REQ: ram_write=1, ram_wdata=cpu_wdata → DONE.
  - RMW_REQ: ram_read=1 → RMW_DATA.
  - RMW_DATA: on the exit edge, register merged = ram_rdata with the addressed byte or half replaced by cpu_wdata[7:0] or [15:0]; the other bytes are untouched → RMW_WR.
  - RMW_WR: ram_write=1, ram_wdata=merged → DONE.
  - DONE: cpu_ready=1 for exactly one cycle; cpu_valid is ignored → IDLE.
- Latency from the accepting edge to the DONE cycle: load 3 cycles, word store 2 cycles, sub-word store 4 cycles, error 1 cycle.
- cpu_rdata holds its last value outside DONE. It is cleared to 0 on stores and on errors.
- ram_read and ram_write are never both 1. Neither is ever asserted in IDLE or DONE.
- Back-to-back: a new cpu_valid is accepted on the first IDLE edge after DONE, so at most one access is in flight.
- Reset mid-operation: state→IDLE and all strobes are 0 from the next cycle. A sub-word store aborted before the RMW_WR edge leaves RAM unmodified. No cpu_ready is issued for the aborted request.
- Input changes while not IDLE are ignored; only the latched copy is used.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - An H/HU/SH access with addr[0]=1, or a W access with addr[1:0]≠0, is an error.
  - funct3 011/110/111 are an error, as are stores with funct3 100/101.
  - An error produces no RAM access, and DONE presents cpu_err=1 with cpu_rdata=0.
- Undefined:
  - cpu_err is tied 0.
  - Misaligned addresses are silently aligned down (H uses addr[1]; W ignores addr[1:0]).
  - Illegal funct3 is treated as W.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF → ram_write=1 one cycle, ram_addr=0x10; cpu_ready 2 cycles after accept; RAM word 4 = 0xDEADBEEF.
- LB addr 0x13 after that store → cpu_rdata=0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF; each has cpu_ready 3 cycles after accept.
- SB addr 0x11 data 0x12345677 → RAM word 4 = 0xDEAD77EF; SH 0x12 data 0xAAAA5555 → 0x555577EF; ram_read then ram_write are seen, and cpu_ready comes 4 cycles after accept.
- Assert rst in the RMW_DATA cycle of SB 0x10 data 0x00 → no ram_write, no cpu_ready, RAM word 4 unchanged, all outputs 0 the next cycle.
- Misalignment:
  - With LSU_MISALIGN_TRAP_EN: LW 0x11 → cpu_ready 1 cycle after accept, cpu_err=1, cpu_rdata=0, no RAM strobe.
  - Without: LW 0x11 returns word 4 and cpu_err=0.
- cpu_valid held continuously across two loads (0x10, then 0x14) → two distinct cpu_ready pulses separated by one IDLE cycle; ram_read and ram_write are never high together.
